// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and constants for the shift-and-add multiplier sequencer.
// Latency: none (declarations only).
// Backpressure: none; mode codes follow the shiftregmodes header if already loaded.
package mult_seq_ctrl_pkg;

  // The shiftregmodes header owns these codes; the guards only cover a build
  // where that header has not been read ahead of this package.
`ifndef SR_HOLD
`define SR_HOLD 2'b00
`endif
`ifndef SR_LEFT
`define SR_LEFT 2'b01
`endif
`ifndef SR_RIGHT
`define SR_RIGHT 2'b10
`endif
`ifndef SR_PLOAD
`define SR_PLOAD 2'b11
`endif

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD  = `SR_HOLD;
  localparam mode_t MODE_LEFT  = `SR_LEFT;
  localparam mode_t MODE_RIGHT = `SR_RIGHT;
  localparam mode_t MODE_PLOAD = `SR_PLOAD;

  // Step counter must be able to hold WIDTH itself (value shown in DONE).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Control bundle between the multiplier sequencer and its datapath/register file.
// Latency: none (wiring only).
// Backpressure: none; start/busy/done is a level handshake, start ignored while busy.
interface mult_seq_ctrl_if
  import mult_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
);
  logic             start;
  logic             abort;
  logic             a_lsb;
  logic             a_zero;
  mode_t            mode_a;
  mode_t            mode_b;
  logic             ser_a;
  logic             ser_b;
  logic             acc_clr;
  logic             acc_add;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] step_cnt;

  // Register file and datapath side: issues commands, reports multiplier bits.
  modport master (
    output start, abort, a_lsb, a_zero,
    input  mode_a, mode_b, ser_a, ser_b, acc_clr, acc_add, busy, done, step_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, abort, a_lsb, a_zero,
    output mode_a, mode_b, ser_a, ser_b, acc_clr, acc_add, busy, done, step_cnt
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-and-add multiplier: LOAD, WIDTH RUN steps, one-cycle DONE.
// Latency: start at edge 0 -> done in cycle WIDTH+2 (shorter with MULT_EARLY_TERM_EN).
// Backpressure: start ignored while busy; abort returns to IDLE on the next edge.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_seq_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             early_stop;

`ifdef MULT_EARLY_TERM_EN
  // Once the multiplier register reports zero, later steps would add nothing.
  assign early_stop = bus.a_zero;
`else
  assign early_stop = 1'b0;
  logic unused_a_zero;
  assign unused_a_zero = bus.a_zero;
`endif

  // Next-state and step-counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = bus.abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (bus.abort) begin
          // Aborted step is not counted; count freezes at steps completed.
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP || early_stop) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset is asynchronous so outputs drop at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode of the datapath controls; only acc_add also looks at a_lsb.
  always_comb begin
    bus.mode_a  = MODE_HOLD;
    bus.mode_b  = MODE_HOLD;
    bus.acc_clr = 1'b0;
    bus.acc_add = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        bus.mode_a  = MODE_PLOAD;
        bus.mode_b  = MODE_PLOAD;
        bus.acc_clr = 1'b1;
        bus.busy    = 1'b1;
      end
      ST_RUN: begin
        // Accumulator samples B before this edge's left shift takes effect.
        bus.mode_a  = MODE_RIGHT;
        bus.mode_b  = MODE_LEFT;
        bus.acc_add = bus.a_lsb;
        bus.busy    = 1'b1;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        bus.busy = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  assign bus.ser_a    = 1'b0;
  assign bus.ser_b    = 1'b0;
  assign bus.step_cnt = cnt_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural shift-register/accumulator datapath.
// Latency: checks done in cycle WIDTH+2 (or the early-term cycle with MULT_EARLY_TERM_EN).
// Backpressure: exercises start-while-busy, held start, abort and async reset.
module tb_mult_seq_ctrl;
  import mult_seq_ctrl_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  mult_seq_ctrl_if #(.WIDTH(W)) bus ();

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec;
  int n_err;

  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W-1:0]   a_reg;
  logic [2*W-1:0] b_reg;
  logic [2*W-1:0] acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: shift registers and accumulator following the mode outputs.
  always @(posedge clk) begin
    case (bus.mode_a)
      MODE_PLOAD: a_reg <= op_a;
      MODE_RIGHT: a_reg <= {bus.ser_a, a_reg[W-1:1]};
      MODE_LEFT:  a_reg <= {a_reg[W-2:0], bus.ser_a};
      default:    a_reg <= a_reg;
    endcase
    case (bus.mode_b)
      MODE_PLOAD: b_reg <= {{W{1'b0}}, op_b};
      MODE_LEFT:  b_reg <= {b_reg[2*W-2:0], bus.ser_b};
      MODE_RIGHT: b_reg <= {bus.ser_b, b_reg[2*W-1:1]};
      default:    b_reg <= b_reg;
    endcase
    if (bus.acc_clr)      acc <= '0;
    else if (bus.acc_add) acc <= acc + b_reg;
  end

  // Zero flag covers the multiplier bits still to be consumed after the current step.
  assign bus.a_lsb  = a_reg[0];
  assign bus.a_zero = (a_reg[W-1:1] == '0);

`ifdef MULT_EARLY_TERM_EN
  localparam int EXP_A3_CYC = 4;
  localparam int EXP_A3_CNT = 2;
  localparam int EXP_A0_CYC = 3;
  localparam int EXP_A0_CNT = 1;
`else
  localparam int EXP_A3_CYC = 10;
  localparam int EXP_A3_CNT = 8;
  localparam int EXP_A0_CYC = 10;
  localparam int EXP_A0_CNT = 8;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_vec++; if (bus.acc_clr !== 1'b0) begin n_err++; $display("FAIL reset_acc_clr got %b want 0", bus.acc_clr); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if (bus.mode_a !== MODE_HOLD) begin n_err++; $display("FAIL idle_mode_a got %b want 00", bus.mode_a); end
    n_vec++; if (bus.mode_b !== MODE_HOLD) begin n_err++; $display("FAIL idle_mode_b got %b want 00", bus.mode_b); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL idle_done got %b want 0", bus.done); end
    n_vec++; if (bus.step_cnt !== 4'd0) begin n_err++; $display("FAIL idle_step_cnt got %0d want 0", bus.step_cnt); end
    n_vec++; if (bus.acc_add !== 1'b0) begin n_err++; $display("FAIL idle_acc_add got %b want 0", bus.acc_add); end
    n_vec++; if ({bus.ser_a, bus.ser_b} !== 2'b00) begin n_err++; $display("FAIL idle_ser got %b want 00", {bus.ser_a, bus.ser_b}); end
  endtask

  task automatic test_single;
    logic [7:0] pat;
    pat  = 8'hB5;
    op_a = 8'hB5;
    op_b = 8'h3C;
    pulse_start();
    // cycle 1: LOAD
    n_vec++; if (bus.mode_a !== MODE_PLOAD) begin n_err++; $display("FAIL load_mode_a got %b want 11", bus.mode_a); end
    n_vec++; if (bus.mode_b !== MODE_PLOAD) begin n_err++; $display("FAIL load_mode_b got %b want 11", bus.mode_b); end
    n_vec++; if (bus.acc_clr !== 1'b1) begin n_err++; $display("FAIL load_acc_clr got %b want 1", bus.acc_clr); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL load_busy got %b want 1", bus.busy); end
    tick();
    // cycles 2..9: RUN
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (bus.mode_a !== MODE_RIGHT || bus.mode_b !== MODE_LEFT) begin
        n_err++; $display("FAIL run_modes step %0d got %b/%b want 10/01", i, bus.mode_a, bus.mode_b);
      end
      n_vec++; if (bus.acc_add !== pat[i]) begin
        n_err++; $display("FAIL run_acc_add step %0d got %b want %b", i, bus.acc_add, pat[i]);
      end
      n_vec++; if (bus.step_cnt !== 4'(i)) begin
        n_err++; $display("FAIL run_step_cnt step %0d got %0d want %0d", i, bus.step_cnt, i);
      end
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL run_done step %0d got %b want 0", i, bus.done); end
      tick();
    end
    // cycle 10: DONE
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL done_cycle10 got %b want 1", bus.done); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL done_busy got %b want 1", bus.busy); end
    n_vec++; if (bus.step_cnt !== 4'd8) begin n_err++; $display("FAIL done_step_cnt got %0d want 8", bus.step_cnt); end
    n_vec++; if (bus.mode_a !== MODE_HOLD || bus.mode_b !== MODE_HOLD) begin
      n_err++; $display("FAIL done_modes got %b/%b want 00/00", bus.mode_a, bus.mode_b);
    end
    n_vec++; if (acc !== 16'h2A6C) begin n_err++; $display("FAIL product_b5x3c got %h want 2a6c", acc); end
    tick();
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_width got %b want 0", bus.done); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL post_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    int ndone;
    int cyc[4];
    int wide;
    int bad_prod;
    logic prev;
    op_a = 8'hFF;
    op_b = 8'hFF;
    ndone = 0; wide = 0; bad_prod = 0; prev = 1'b0;
    bus.start = 1'b1;
    tick();
    for (int c = 1; c <= 35; c++) begin
      if (bus.done === 1'b1) begin
        if (prev) wide++;
        if (acc !== 16'hFE01) bad_prod++;
        if (ndone < 4) cyc[ndone] = c;
        ndone++;
      end
      prev = bus.done;
      tick();
    end
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    n_vec++; if (ndone !== 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", ndone); end
    n_vec++; if (ndone > 0 && cyc[0] !== 10) begin n_err++; $display("FAIL b2b_first got %0d want 10", cyc[0]); end
    n_vec++; if (ndone > 1 && cyc[1] !== 21) begin n_err++; $display("FAIL b2b_second got %0d want 21", cyc[1]); end
    n_vec++; if (ndone > 2 && cyc[2] !== 32) begin n_err++; $display("FAIL b2b_third got %0d want 32", cyc[2]); end
    n_vec++; if (wide !== 0) begin n_err++; $display("FAIL b2b_done_wide got %0d want 0", wide); end
    n_vec++; if (bad_prod !== 0) begin n_err++; $display("FAIL b2b_product_ffxff got %0d bad want 0", bad_prod); end
  endtask

  task automatic test_abort;
    int seen;
    op_a = 8'hB5;
    op_b = 8'h3C;
    pulse_start();
    tick();
    for (int i = 0; i < 3; i++) tick();
    // cycle 5: fourth RUN cycle
    n_vec++; if (bus.step_cnt !== 4'd3) begin n_err++; $display("FAIL abort_pre_cnt got %0d want 3", bus.step_cnt); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.mode_a !== MODE_HOLD || bus.mode_b !== MODE_HOLD) begin
      n_err++; $display("FAIL abort_modes got %b/%b want 00/00", bus.mode_a, bus.mode_b);
    end
    n_vec++; if (bus.step_cnt !== 4'd3) begin n_err++; $display("FAIL abort_cnt got %0d want 3", bus.step_cnt); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done !== 1'b0) seen++;
      tick();
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_done got %0d want 0", seen); end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_prio_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.step_cnt !== 4'd3) begin n_err++; $display("FAIL abort_prio_cnt got %0d want 3", bus.step_cnt); end
  endtask

  task automatic test_async_reset;
    int dcyc;
    op_a = 8'h0D;
    op_b = 8'h07;
    pulse_start();
    for (int i = 0; i < 3; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.mode_a !== MODE_HOLD || bus.mode_b !== MODE_HOLD) begin
      n_err++; $display("FAIL arst_modes got %b/%b want 00/00", bus.mode_a, bus.mode_b);
    end
    n_vec++; if (bus.step_cnt !== 4'd0) begin n_err++; $display("FAIL arst_cnt got %0d want 0", bus.step_cnt); end
    n_vec++; if (bus.acc_add !== 1'b0 || bus.acc_clr !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL arst_strobes got add=%b clr=%b done=%b want 0", bus.acc_add, bus.acc_clr, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pulse_start();
    dcyc = 0;
    for (int c = 1; c <= 14; c++) begin
      if (bus.done === 1'b1 && dcyc == 0) dcyc = c;
      if (dcyc == c) begin
        n_vec++; if (acc !== 16'h005B) begin n_err++; $display("FAIL arst_product got %h want 005b", acc); end
      end
      tick();
    end
    n_vec++; if (dcyc !== 10) begin n_err++; $display("FAIL arst_done_cycle got %0d want 10", dcyc); end
  endtask

  task automatic test_early_term;
    int dcyc;
    logic [3:0] dcnt;
    logic [15:0] dacc;
    op_a = 8'h03;
    op_b = 8'h3C;
    pulse_start();
    dcyc = 0; dcnt = '0; dacc = '0;
    for (int c = 1; c <= 12; c++) begin
      if (bus.done === 1'b1 && dcyc == 0) begin dcyc = c; dcnt = bus.step_cnt; dacc = acc; end
      tick();
    end
    n_vec++; if (dcyc !== EXP_A3_CYC) begin n_err++; $display("FAIL et_a3_cycle got %0d want %0d", dcyc, EXP_A3_CYC); end
    n_vec++; if (dcnt !== 4'(EXP_A3_CNT)) begin n_err++; $display("FAIL et_a3_cnt got %0d want %0d", dcnt, EXP_A3_CNT); end
    n_vec++; if (dacc !== 16'h00B4) begin n_err++; $display("FAIL et_a3_product got %h want 00b4", dacc); end
    op_a = 8'h00;
    pulse_start();
    dcyc = 0; dcnt = '0; dacc = 16'hFFFF;
    for (int c = 1; c <= 12; c++) begin
      if (bus.done === 1'b1 && dcyc == 0) begin dcyc = c; dcnt = bus.step_cnt; dacc = acc; end
      tick();
    end
    n_vec++; if (dcyc !== EXP_A0_CYC) begin n_err++; $display("FAIL et_a0_cycle got %0d want %0d", dcyc, EXP_A0_CYC); end
    n_vec++; if (dcnt !== 4'(EXP_A0_CNT)) begin n_err++; $display("FAIL et_a0_cnt got %0d want %0d", dcnt, EXP_A0_CNT); end
    n_vec++; if (dacc !== 16'h0000) begin n_err++; $display("FAIL et_a0_product got %h want 0000", dacc); end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    op_a      = '0;
    op_b      = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_early_term();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
